// File: rtl/time_display_pkg.sv
// time_display_pkg
// Shared definitions for the stopwatch display back end: active-low
// seven-segment glyph constants ({dp,g,f,e,d,c,b,a}), the display mode
// enum and a digit-to-glyph helper.
package time_display_pkg;

    localparam logic [7:0] SEG_BLANK   = 8'hFF;
    localparam logic [7:0] SEG_DASH    = 8'hBF;
    localparam logic [7:0] SEG_DP_MASK = 8'h7F;  // AND-mask that lights dp

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;

    typedef enum logic {
        LIVE   = 1'b0,
        FROZEN = 1'b1
    } mode_e;

    // Glyph for a BCD digit; anything outside 0-9 shows a dash.
    function automatic logic [7:0] glyph(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/time_display_seg7_decode.sv
// seg7_decode
// Purely combinational digit decoder with a per-position range limit.
// Ports:
//   i_digit  4-bit digit to show
//   i_max    largest legal value for this display position
//   o_seg    active-low glyph {dp,g,f,e,d,c,b,a}, dp off; dash if out of range
module seg7_decode
    import time_display_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic [3:0] i_max,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        if (i_digit <= i_max) begin
            o_seg = glyph(i_digit);
        end
    end

endmodule

// File: rtl/time_display.sv
// time_display
// Stopwatch display back end for four DE10-Lite HEX displays (MM.SS).
// Shadows the BCD time digits (live or lap-frozen), decodes them to
// registered seven-segment outputs, blanks a leading minute-tens zero,
// lights the MM.SS separator and blinks the whole display while paused.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sec_ones     BCD 0-9       sec_tens   BCD 0-5
//   min_ones     BCD 0-9       min_tens   BCD 0-9
//   blink_en     level, enables blinking (paused)
//   lap_capture  pulse, freeze the shown time
//   lap_release  pulse, return to the live time
//   hex0..hex3   active-low segments {dp,g,f,e,d,c,b,a}; hex0 = sec_ones
//   frozen       high while the display is lap-frozen
module time_display
    import time_display_pkg::*;
#(
    parameter int unsigned BLINK_HALF = 25_000_000,
    parameter bit          LZ_BLANK   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sec_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] min_tens,
    input  logic       blink_en,
    input  logic       lap_capture,
    input  logic       lap_release,
    output logic [7:0] hex0,
    output logic [7:0] hex1,
    output logic [7:0] hex2,
    output logic [7:0] hex3,
    output logic       frozen
);

    localparam int unsigned CW = $clog2(BLINK_HALF);

    mode_e            r_state;
    mode_e            w_state_next;
    logic             w_load;
    logic [3:0][3:0]  r_digit;     // [0]=sec_ones .. [3]=min_tens
    logic [CW-1:0]    r_blink_cnt;
    logic             r_phase;
    logic [3:0][7:0]  w_seg;
    logic [3:0][7:0]  w_hex_next;
    logic [3:0][7:0]  r_hex;

    // ---------------- mode FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LIVE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            LIVE:   if (lap_capture && !lap_release) w_state_next = FROZEN;
            FROZEN: if (lap_release && !lap_capture) w_state_next = LIVE;
            default: w_state_next = LIVE;
        endcase
    end

    // Shadows also load in the release cycle so the live time reaches the
    // outputs with the same 2-cycle latency as an ordinary digit change.
    assign w_load = (r_state == LIVE) || (w_state_next == LIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= '0;
        end else if (w_load) begin
            r_digit <= {min_tens, min_ones, sec_tens, sec_ones};
        end
    end

    // ---------------- blink timer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (!blink_en) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == CW'(BLINK_HALF - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + CW'(1);
        end
    end

    // ---------------- decode ----------------
    seg7_decode u_dec_sec_ones (.i_digit(r_digit[0]), .i_max(4'd9), .o_seg(w_seg[0]));
    seg7_decode u_dec_sec_tens (.i_digit(r_digit[1]), .i_max(4'd5), .o_seg(w_seg[1]));
    seg7_decode u_dec_min_ones (.i_digit(r_digit[2]), .i_max(4'd9), .o_seg(w_seg[2]));
    seg7_decode u_dec_min_tens (.i_digit(r_digit[3]), .i_max(4'd9), .o_seg(w_seg[3]));

    // ---------------- blanking mux ----------------
    always_comb begin
        w_hex_next    = w_seg;
        w_hex_next[2] = w_seg[2] & SEG_DP_MASK;   // MM.SS separator
        if (LZ_BLANK && (r_digit[3] == 4'd0)) begin
            w_hex_next[3] = SEG_BLANK;
        end
        // blink_en is used unregistered so the display returns one cycle
        // after it drops, without waiting for the phase register to clear.
        if (blink_en && r_phase) begin
            w_hex_next = {4{SEG_BLANK}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex <= '1;
        end else begin
            r_hex <= w_hex_next;
        end
    end

    assign hex0   = r_hex[0];
    assign hex1   = r_hex[1];
    assign hex2   = r_hex[2];
    assign hex3   = r_hex[3];
    assign frozen = (r_state == FROZEN);

endmodule

// File: tb/tb_time_display.sv
// tb_time_display
// Self-checking bench for time_display (BLINK_HALF = 4, LZ_BLANK = 1).
// A reference model pushes the expected outputs on every clock edge; a
// monitor pops them on the falling edge and compares. Directed spot checks
// with literal glyph values cover the scenario points.
module tb_time_display;

    localparam int unsigned BH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] sec_ones = '0, sec_tens = '0, min_ones = '0, min_tens = '0;
    logic       blink_en = 1'b0, lap_capture = 1'b0, lap_release = 1'b0;
    logic [7:0] hex0, hex1, hex2, hex3;
    logic       frozen;

    int n_cmp = 0;
    int n_err = 0;

    time_display #(.BLINK_HALF(BH), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min_ones(min_ones), .min_tens(min_tens),
        .blink_en(blink_en), .lap_capture(lap_capture), .lap_release(lap_release),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .frozen(frozen)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] h3, h2, h1, h0;
        logic       fz;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] m_d0 = '0, m_d1 = '0, m_d2 = '0, m_d3 = '0;
    logic       m_fz = 1'b0, m_ph = 1'b0;
    int         m_cnt = 0;

    function automatic logic [7:0] ref_glyph(input logic [3:0] d, input int mx);
        if (d > mx) return 8'hBF;
        case (d)
            4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
            4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
            4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
            default: return 8'h90;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            m_d0 = '0; m_d1 = '0; m_d2 = '0; m_d3 = '0;
            m_fz = 1'b0; m_ph = 1'b0; m_cnt = 0;
            if (clk) sb_q.push_back({8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0});
            else sb_q.delete();
        end else begin
            e.h0 = ref_glyph(m_d0, 9);
            e.h1 = ref_glyph(m_d1, 5);
            e.h2 = {1'b0, ref_glyph(m_d2, 9) & 8'h7F} [7:0];
            e.h3 = (m_d3 == 4'd0) ? 8'hFF : ref_glyph(m_d3, 9);
            if (blink_en && m_ph) begin
                e.h0 = 8'hFF; e.h1 = 8'hFF; e.h2 = 8'hFF; e.h3 = 8'hFF;
            end
            if (!m_fz || (lap_release && !lap_capture)) begin
                m_d0 = sec_ones; m_d1 = sec_tens; m_d2 = min_ones; m_d3 = min_tens;
            end
            if (!m_fz && lap_capture && !lap_release) m_fz = 1'b1;
            else if (m_fz && lap_release && !lap_capture) m_fz = 1'b0;
            if (!blink_en) begin
                m_cnt = 0; m_ph = 1'b0;
            end else if (m_cnt == BH - 1) begin
                m_cnt = 0; m_ph = ~m_ph;
            end else begin
                m_cnt++;
            end
            e.fz = m_fz;
            sb_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("sb_hex0", {24'd0, hex0}, {24'd0, e.h0});
            check_val("sb_hex1", {24'd0, hex1}, {24'd0, e.h1});
            check_val("sb_hex2", {24'd0, hex2}, {24'd0, e.h2});
            check_val("sb_hex3", {24'd0, hex3}, {24'd0, e.h3});
            check_val("sb_frozen", {31'd0, frozen}, {31'd0, e.fz});
        end
    end

    task automatic set_digits(input logic [3:0] mt, input logic [3:0] mo,
                              input logic [3:0] st, input logic [3:0] so);
        min_tens = mt; min_ones = mo; sec_tens = st; sec_ones = so;
    endtask

    task automatic check_hex(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                             input logic [7:0] e1, input logic [7:0] e0);
        check_val({tag, "_hex3"}, {24'd0, hex3}, {24'd0, e3});
        check_val({tag, "_hex2"}, {24'd0, hex2}, {24'd0, e2});
        check_val({tag, "_hex1"}, {24'd0, hex1}, {24'd0, e1});
        check_val({tag, "_hex0"}, {24'd0, hex0}, {24'd0, e0});
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        #1 rst_n = 1'b0;
        #2;
        check_hex("reset", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        check_val("reset_frozen", {31'd0, frozen}, 32'd0);
        cyc(2);

        // live decode with leading-zero blank: 0 2 : 3 4
        rst_n = 1'b1;
        set_digits(4'd0, 4'd2, 4'd3, 4'd4);
        cyc(2);
        check_hex("live", 8'hFF, 8'h24, 8'hB0, 8'h99);
        check_val("live_frozen", {31'd0, frozen}, 32'd0);

        // lap freeze on 15:59, inputs move on to 16:00
        set_digits(4'd1, 4'd5, 4'd5, 4'd9);
        cyc(1);
        lap_capture = 1'b1;
        cyc(1);
        lap_capture = 1'b0;
        set_digits(4'd1, 4'd6, 4'd0, 4'd0);
        check_val("cap_frozen", {31'd0, frozen}, 32'd1);
        cyc(3);
        check_hex("held", 8'hF9, 8'h12, 8'h92, 8'h90);
        lap_release = 1'b1;
        cyc(1);
        lap_release = 1'b0;
        check_val("rel_frozen", {31'd0, frozen}, 32'd0);
        cyc(1);
        check_hex("released", 8'hF9, 8'h02, 8'hC0, 8'hC0);

        // simultaneous capture+release changes nothing
        lap_capture = 1'b1; lap_release = 1'b1;
        cyc(1);
        lap_capture = 1'b0; lap_release = 1'b0;
        check_val("both_live", {31'd0, frozen}, 32'd0);
        lap_capture = 1'b1;
        cyc(1);
        lap_capture = 1'b0;
        check_val("cap2", {31'd0, frozen}, 32'd1);
        lap_capture = 1'b1; lap_release = 1'b1;
        cyc(1);
        lap_capture = 1'b0; lap_release = 1'b0;
        check_val("both_frozen", {31'd0, frozen}, 32'd1);
        lap_release = 1'b1;
        cyc(1);
        lap_release = 1'b0;
        check_val("rel2", {31'd0, frozen}, 32'd0);

        // freeze 23:48, then blink while frozen
        set_digits(4'd2, 4'd3, 4'd4, 4'd8);
        cyc(1);
        lap_capture = 1'b1;
        cyc(1);
        lap_capture = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        cyc(2);
        blink_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc(1);
            if (((k - 1) / BH) % 2 == 1) begin
                check_val($sformatf("blink%0d_hex0", k), {24'd0, hex0}, 32'hFF);
                check_val($sformatf("blink%0d_hex2", k), {24'd0, hex2}, 32'hFF);
            end else begin
                check_val($sformatf("blink%0d_hex0", k), {24'd0, hex0}, 32'h80);
                check_val($sformatf("blink%0d_hex2", k), {24'd0, hex2}, 32'h30);
            end
        end
        blink_en = 1'b0;
        cyc(1);
        check_hex("unblink", 8'hA4, 8'h30, 8'h99, 8'h80);

        // out-of-range digits show a dash
        lap_release = 1'b1;
        cyc(1);
        lap_release = 1'b0;
        set_digits(4'd3, 4'd12, 4'd7, 4'd8);
        cyc(2);
        check_hex("dash", 8'hB0, 8'h3F, 8'hBF, 8'h80);

        // reset mid-blink while frozen
        lap_capture = 1'b1;
        cyc(1);
        lap_capture = 1'b0;
        blink_en = 1'b1;
        cyc(7);
        #2 rst_n = 1'b0;
        #1;
        check_hex("async_rst", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        check_val("async_rst_frozen", {31'd0, frozen}, 32'd0);
        blink_en = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        set_digits(4'd4, 4'd5, 4'd2, 4'd1);
        cyc(2);
        check_hex("post_rst", 8'h99, 8'h12, 8'hA4, 8'hF9);
        check_val("post_rst_frozen", {31'd0, frozen}, 32'd0);

        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/time_display.md
# time_display

Display back end for the stopwatch: consumes the four BCD time digits that the time counter produces and drives four DE10-Lite HEX displays (HEX3..HEX0 = MM.SS). The block adds registered seven-segment decode, leading-zero blanking, a lap-freeze hold, a pause blink, and marking of invalid digits. It sits between the time counter / control FSM and the board HEX pins, and runs on the 50 MHz system clock.

## Interface
Parameters:
- BLINK_HALF, default 25_000_000: clock cycles per blink half-period; legal range is 2 or more.
- LZ_BLANK, default 1: when 1, blank HEX3 if min_tens == 0.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, asynchronous and active-low.
- sec_ones  in  4  BCD, legal range 0–9.
- sec_tens  in  4  BCD, legal range 0–5.
- min_ones  in  4  BCD, legal range 0–9.
- min_tens  in  4  BCD, legal range 0–9.
- blink_en  in  1  level input from the FSM (paused state); enables blinking.
- lap_capture  in  1  one-cycle pulse; freezes the shown time.
- lap_release  in  1  one-cycle pulse; returns to live display.
- hex0..hex3  out  8 each  segments {dp,g,f,e,d,c,b,a}, active-low; hex0 = sec_ones, hex3 = min_tens.
- frozen  out  1  high while in the FROZEN state.

## Operation
- Mode FSM has two states:
  - LIVE (reset state): the shadow digit registers load all four inputs every cycle.
  - FROZEN: the shadow registers hold.
- Mode transitions:
  - LIVE→FROZEN on lap_capture. The shadow registers take the values present on the inputs in that same cycle.
  - FROZEN→LIVE on lap_release.
  - If lap_capture and lap_release are high in the same cycle, the state does not change.
  - lap_capture while FROZEN and lap_release while LIVE are ignored.
  - frozen = (state == FROZEN), registered.
- Decode of each shadow digit:
  - 0–9 map to standard glyphs. 0 = 8'hC0, 1 = 8'hF9, 8 = 8'h80.
  - Any value above 9, or sec_tens above 5, shows a dash, 8'hBF (segment g only).
- Leading-zero blanking: if LZ_BLANK = 1 and shadow min_tens == 0, hex3 = 8'hFF. No other digit is ever blanked by this rule.
- Separator: hex2 bit 7 (dp) = 0 (lit) whenever the digits are visible. The dp bit on hex0, hex1 and hex3 is always 1.
- Blink:
  - A counter runs 0..BLINK_HALF-1 while blink_en = 1. It wraps to 0 and toggles phase on reaching BLINK_HALF-1.
  - When blink_en = 0, the counter is forced to 0 and phase to 0 synchronously.
  - phase = 1 with blink_en = 1 forces all four outputs to 8'hFF, separator included.
- Blink and FROZEN are independent. A frozen display still blinks if blink_en = 1.

## Timing
- Reset values: hex0..hex3 = 8'hFF, frozen = 0, state LIVE, blink counter 0, phase 0, shadow registers 0.
- Latency:
  - A digit input change reaches the hex outputs 2 cycles later (shadow register, then registered decode).
  - frozen rises 1 cycle after lap_capture.
- Blink period:
  - After blink_en rises in cycle N, the outputs are first blanked in cycle N+BLINK_HALF+1.
  - After that, the visible/blank pattern alternates every BLINK_HALF cycles.
- When blink_en falls, the outputs are visible again 1 cycle later.
- Reset asserted mid-operation: all state clears immediately (asynchronous). The first decoded outputs appear 2 cycles after rst_n deasserts.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package contents:
  - segment constants SEG_BLANK = 8'hFF and SEG_DASH = 8'hBF;
  - the 0–9 glyph constants;
  - the mode enum {LIVE, FROZEN}.
- One sub-module, seg7_decode (purely combinational):
  - inputs: a 4-bit digit and a 4-bit maximum legal value;
  - output: the 7-segment glyph, or dash when the digit is out of range.
  - It is instantiated four times: max 9 for three digits, max 5 for sec_tens.
- The top level holds the mode FSM, the shadow registers, the blink counter, the blanking mux and the output registers.

## Test plan
- Reset, then drive digits 0,2,3,4 (min_tens..sec_ones) with LZ_BLANK = 1 → after 2 cycles:
  - hex3 = FF, hex2 = 0x24 ("2", dp lit), hex1 = B0, hex0 = 99; frozen = 0.
- Drive digits 1,5,5,9 and pulse lap_capture; change the inputs to 1,6,0,0 → frozen = 1 and the outputs keep showing 15:59. Pulse lap_release → 16:00 shown 2 cycles later.
- Pulse lap_capture and lap_release in the same cycle while LIVE, then again while FROZEN → frozen does not change in either case.
- With BLINK_HALF = 4, raise blink_en:
  - blanking (all FF) starts on cycle N+5, then the pattern alternates every 4 cycles;
  - drop blink_en while blanked → visible again 1 cycle later.
- Drive sec_tens = 7 and min_ones = 12 → hex1 = BF and hex2 = 3F (dash, dp lit); the other digits decode normally.
- Assert rst_n low mid-blink while FROZEN → all outputs FF and frozen = 0 in the same cycle. After release, live digits appear 2 cycles later.
